// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings for the memory-access stage
//
// Purpose: op encodings, FSM state encoding and a small op-decode helper
//          shared by mem_access_unit and its bench.
// Ports:   none (package).

package mem_access_unit_pkg;

   localparam logic [1:0] MEM_OP_PASS  = 2'b00;
   localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
   localparam logic [1:0] MEM_OP_STORE = 2'b10;
   localparam logic [1:0] MEM_OP_RSVD  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mau_state_t;

   // Reserved op behaves exactly like pass, so only load/store touch memory.
   function automatic logic is_mem_op(input logic [1:0] op);
      return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-cycle counter with expire flag for the memory stage
//
// Purpose: counts cycles spent waiting for mem_ack and flags the cycle in
//          which the TIMEOUT_CYCLES-th un-acked wait cycle occurs.
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_start   clear the count (asserted on the edge that enters WAIT)
//   i_active  in WAIT without ack this cycle
//   o_expire  this cycle is the last allowed wait cycle (combinational)

module mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_start,
   input  logic i_active,
   output logic o_expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= '0;
      end else if (i_active) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // The count equals the number of un-acked wait cycles already completed,
   // so LAST marks the TIMEOUT_CYCLES-th such cycle.
   assign o_expire = i_active && (r_cnt == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-access pipeline stage with req/ack data-memory port
//
// Purpose: takes the execute-stage result, forwards pass ops to writeback
//          with one cycle latency, and runs a req/ack transaction for loads
//          and stores while stalling upstream.
// Optional: MEM_ACCESS_TIMEOUT_EN adds a wait timeout (mem_wait_timer) that
//           aborts with a one-cycle o_mem_fault pulse.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_ex_valid/op/result/store_data/rd/wb_en   execute-stage instruction
//   i_flush                         squash input / suppress pending writeback
//   o_stall                         upstream must hold (state == WAIT)
//   o_mem_req/we/addr/wdata         data-memory request
//   i_mem_ack, i_mem_rdata          data-memory completion and load data
//   o_wb_valid/we/rd/data           writeback slot
//   o_mem_fault                     timeout abort pulse (0 without the option)

module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DW             = 16,
   parameter int RW             = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_ex_valid,
   input  logic [1:0]    i_ex_op,
   input  logic [DW-1:0] i_ex_result,
   input  logic [DW-1:0] i_ex_store_data,
   input  logic [RW-1:0] i_ex_rd,
   input  logic          i_ex_wb_en,
   input  logic          i_flush,
   output logic          o_stall,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [DW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic          i_mem_ack,
   input  logic [DW-1:0] i_mem_rdata,
   output logic          o_wb_valid,
   output logic          o_wb_we,
   output logic [RW-1:0] o_wb_rd,
   output logic [DW-1:0] o_wb_data,
   output logic          o_mem_fault
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   mau_state_t    r_state;
   logic          r_is_store;
   logic [DW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [RW-1:0] r_rd;
   logic          r_wb_en;
   logic          r_flushed;
   logic          r_wb_valid;
   logic          r_wb_we;
   logic [RW-1:0] r_wb_rd;
   logic [DW-1:0] r_wb_data;
   logic          w_in_wait;
   logic          w_accept_mem;

   assign w_in_wait    = (r_state == ST_WAIT);
   assign w_accept_mem = (r_state == ST_IDLE) && i_ex_valid && !i_flush && is_mem_op(i_ex_op);

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic w_timeout;
   logic r_mem_fault;

   mem_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_start  (w_accept_mem),
      .i_active (w_in_wait && !i_mem_ack),
      .o_expire (w_timeout)
   );

   assign o_mem_fault = r_mem_fault;
`else
   assign o_mem_fault = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_is_store <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd       <= '0;
         r_wb_en    <= 1'b0;
         r_flushed  <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_we    <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         r_mem_fault <= 1'b0;
`endif
      end else begin
         r_wb_valid <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         r_mem_fault <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_accept_mem) begin
                  r_state    <= ST_WAIT;
                  r_is_store <= (i_ex_op == MEM_OP_STORE);
                  r_addr     <= i_ex_result;
                  r_wdata    <= i_ex_store_data;
                  r_rd       <= i_ex_rd;
                  r_wb_en    <= i_ex_wb_en;
                  r_flushed  <= 1'b0;
               end else if (i_ex_valid && !i_flush) begin
                  // pass and reserved ops go straight to writeback
                  r_wb_valid <= 1'b1;
                  r_wb_we    <= i_ex_wb_en;
                  r_wb_rd    <= i_ex_rd;
                  r_wb_data  <= i_ex_result;
               end
            end
            ST_WAIT: begin
               if (i_mem_ack) begin
                  // a flush seen in the ack cycle itself also squashes the result
                  r_state    <= ST_IDLE;
                  r_flushed  <= 1'b0;
                  r_wb_valid <= !(r_flushed || i_flush);
                  r_wb_we    <= !r_is_store && r_wb_en;
                  r_wb_rd    <= r_rd;
                  r_wb_data  <= r_is_store ? '0 : i_mem_rdata;
`ifdef MEM_ACCESS_TIMEOUT_EN
               end else if (w_timeout) begin
                  r_state     <= ST_IDLE;
                  r_flushed   <= 1'b0;
                  r_mem_fault <= 1'b1;
                  r_wb_valid  <= 1'b1;
                  r_wb_we     <= 1'b0;
                  r_wb_rd     <= r_rd;
                  r_wb_data   <= '0;
`endif
               end else if (i_flush) begin
                  r_flushed <= 1'b1;
               end
            end
         endcase
      end
   end

   assign o_stall     = w_in_wait;
   assign o_mem_req   = w_in_wait;
   assign o_mem_we    = w_in_wait && r_is_store;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_wb_valid  = r_wb_valid;
   assign o_wb_we     = r_wb_we;
   assign o_wb_rd     = r_wb_rd;
   assign o_wb_data   = r_wb_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit

module tb_mem_access_unit;

   localparam int DW = 16;
   localparam int RW = 3;
   localparam int TO = 4;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_ex_valid;
   logic [1:0]    i_ex_op;
   logic [DW-1:0] i_ex_result;
   logic [DW-1:0] i_ex_store_data;
   logic [RW-1:0] i_ex_rd;
   logic          i_ex_wb_en;
   logic          i_flush;
   logic          o_stall;
   logic          o_mem_req;
   logic          o_mem_we;
   logic [DW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic          i_mem_ack;
   logic [DW-1:0] i_mem_rdata;
   logic          o_wb_valid;
   logic          o_wb_we;
   logic [RW-1:0] o_wb_rd;
   logic [DW-1:0] o_wb_data;
   logic          o_mem_fault;

   int checks   = 0;
   int failures = 0;

   // responder RAM (driven by what the DUT puts on the bus) and reference
   // memory (updated from instruction semantics only)
   logic [DW-1:0] ram     [logic [DW-1:0]];
   logic [DW-1:0] ref_mem [logic [DW-1:0]];

   always #5 i_clk = ~i_clk;

   mem_access_unit #(
      .DW(DW), .RW(RW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_ex_valid(i_ex_valid), .i_ex_op(i_ex_op), .i_ex_result(i_ex_result),
      .i_ex_store_data(i_ex_store_data), .i_ex_rd(i_ex_rd), .i_ex_wb_en(i_ex_wb_en),
      .i_flush(i_flush), .o_stall(o_stall),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
      .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd),
      .o_wb_data(o_wb_data), .o_mem_fault(o_mem_fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] ram_rd(input logic [DW-1:0] a);
      return ram.exists(a) ? ram[a] : '0;
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [DW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : '0;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // One instruction from issue to writeback; flush_k >= 0 pulses flush in
   // that wait cycle. Entered and left 1 time unit after a rising edge.
   task automatic run_instr(input logic [1:0] op, input logic [DW-1:0] res,
                            input logic [DW-1:0] sd, input logic [RW-1:0] rd,
                            input logic wben, input int lat, input int flush_k,
                            input string tag);
      bit            is_load, is_store;
      logic [DW-1:0] exp_data;
      is_load  = (op == 2'b01);
      is_store = (op == 2'b10);
      exp_data = is_load ? ref_rd(res) : '0;
      if (is_store) ref_mem[res] = sd;

      i_ex_valid = 1'b1; i_ex_op = op; i_ex_result = res;
      i_ex_store_data = sd; i_ex_rd = rd; i_ex_wb_en = wben;
      tick();
      i_ex_valid = 1'b0;
      i_ex_result = DW'($urandom);

      if (!is_load && !is_store) begin
         chk({tag, ".wb_valid"}, o_wb_valid, 1);
         chk({tag, ".wb_we"}, o_wb_we, wben);
         chk({tag, ".wb_rd"}, o_wb_rd, rd);
         chk({tag, ".wb_data"}, o_wb_data, res);
         chk({tag, ".stall"}, o_stall, 0);
         chk({tag, ".mem_req"}, o_mem_req, 0);
      end else begin
         for (int k = 0; k <= lat; k++) begin
            chk({tag, ".wait_stall"}, o_stall, 1);
            chk({tag, ".wait_req"}, o_mem_req, 1);
            chk({tag, ".wait_we"}, o_mem_we, is_store);
            chk({tag, ".wait_addr"}, o_mem_addr, res);
            if (is_store) chk({tag, ".wait_wdata"}, o_mem_wdata, sd);
            chk({tag, ".wait_wbv"}, o_wb_valid, 0);
            chk({tag, ".wait_fault"}, o_mem_fault, 0);
            i_flush = (k == flush_k);
            if (k == lat) begin
               i_mem_ack = 1'b1;
               if (o_mem_we) begin
                  ram[o_mem_addr] = o_mem_wdata;
                  i_mem_rdata = DW'($urandom);
               end else begin
                  i_mem_rdata = ram_rd(o_mem_addr);
               end
            end
            tick();
            i_mem_ack = 1'b0;
            i_flush = 1'b0;
         end
         chk({tag, ".done_stall"}, o_stall, 0);
         chk({tag, ".done_req"}, o_mem_req, 0);
         chk({tag, ".done_wbv"}, o_wb_valid, (flush_k < 0));
         if (flush_k < 0) begin
            chk({tag, ".done_we"}, o_wb_we, is_load && wben);
            chk({tag, ".done_rd"}, o_wb_rd, rd);
            chk({tag, ".done_data"}, o_wb_data, exp_data);
         end
      end
   endtask

   // A cycle in which nothing should issue (ex_valid low or flushed input).
   task automatic idle_cycle(input logic v, input logic f, input logic stray_ack);
      i_ex_valid = v; i_flush = f; i_mem_ack = stray_ack;
      i_ex_op = 2'($urandom); i_mem_rdata = DW'($urandom);
      tick();
      i_ex_valid = 1'b0; i_flush = 1'b0; i_mem_ack = 1'b0;
      chk("idle.wb_valid", o_wb_valid, 0);
      chk("idle.stall", o_stall, 0);
      chk("idle.mem_req", o_mem_req, 0);
   endtask

   initial begin
      logic [1:0]    r_op;
      logic [DW-1:0] r_res;
      int            r_lat;
      int            r_fk;
      logic          r_v;

      i_rst_n = 1'b0; i_ex_valid = 1'b0; i_ex_op = '0; i_ex_result = '0;
      i_ex_store_data = '0; i_ex_rd = '0; i_ex_wb_en = 1'b0; i_flush = 1'b0;
      i_mem_ack = 1'b0; i_mem_rdata = '0;
      #2;
      chk("rst.stall", o_stall, 0);
      chk("rst.mem_req", o_mem_req, 0);
      chk("rst.wb_valid", o_wb_valid, 0);
      chk("rst.mem_fault", o_mem_fault, 0);
      chk("rst.wb_data", o_wb_data, 0);
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();

      // directed pass
      run_instr(2'b00, 16'h1234, 16'h0000, 3'd5, 1'b1, 0, -1, "pass");

      // directed load, 3-cycle latency, next instruction held during stall
      ram[16'h0040] = 16'hBEEF;
      ref_mem[16'h0040] = 16'hBEEF;
      i_ex_valid = 1'b1; i_ex_op = 2'b01; i_ex_result = 16'h0040;
      i_ex_rd = 3'd2; i_ex_wb_en = 1'b1;
      tick();
      i_ex_op = 2'b00; i_ex_result = 16'h5A5A; i_ex_rd = 3'd7;
      for (int k = 0; k < 3; k++) begin
         chk("load3.req", o_mem_req, 1);
         chk("load3.addr", o_mem_addr, 16'h0040);
         chk("load3.we", o_mem_we, 0);
         chk("load3.stall", o_stall, 1);
         if (k == 2) begin
            i_mem_ack = 1'b1;
            i_mem_rdata = 16'hBEEF;
         end
         tick();
         i_mem_ack = 1'b0;
      end
      chk("load3.wbv", o_wb_valid, 1);
      chk("load3.data", o_wb_data, 16'hBEEF);
      chk("load3.wbwe", o_wb_we, 1);
      chk("load3.rd", o_wb_rd, 2);
      chk("load3.stall_low", o_stall, 0);
      tick();
      i_ex_valid = 1'b0;
      chk("held.wbv", o_wb_valid, 1);
      chk("held.data", o_wb_data, 16'h5A5A);
      chk("held.rd", o_wb_rd, 7);

      // directed store, zero wait
      run_instr(2'b10, 16'h0100, 16'h00FF, 3'd3, 1'b1, 0, -1, "store0");

      // flush during load wait, then a normal pass op
      run_instr(2'b01, 16'h0100, 16'h0000, 3'd4, 1'b1, 2, 1, "flushld");
      run_instr(2'b11, 16'hA5A5, 16'h0000, 3'd6, 1'b1, 0, -1, "rsvdpass");
      idle_cycle(1'b0, 1'b0, 1'b1);
      idle_cycle(1'b1, 1'b1, 1'b0);

      // reset in the middle of a wait
      i_ex_valid = 1'b1; i_ex_op = 2'b01; i_ex_result = 16'h0022; i_ex_rd = 3'd1;
      tick();
      i_ex_valid = 1'b0;
      chk("rstwait.req_before", o_mem_req, 1);
      i_rst_n = 1'b0;
      #1;
      chk("rstwait.req", o_mem_req, 0);
      chk("rstwait.stall", o_stall, 0);
      chk("rstwait.wbv", o_wb_valid, 0);
      tick();
      i_rst_n = 1'b1;
      tick();
      run_instr(2'b01, 16'h0100, 16'h0000, 3'd5, 1'b1, 1, -1, "postrst");

`ifdef MEM_ACCESS_TIMEOUT_EN
      i_ex_valid = 1'b1; i_ex_op = 2'b01; i_ex_result = 16'h0300; i_ex_rd = 3'd3;
      i_ex_wb_en = 1'b1;
      tick();
      i_ex_valid = 1'b0;
      for (int k = 0; k < TO; k++) begin
         chk("tmo.req", o_mem_req, 1);
         chk("tmo.nofault", o_mem_fault, 0);
         tick();
      end
      chk("tmo.fault", o_mem_fault, 1);
      chk("tmo.req_drop", o_mem_req, 0);
      chk("tmo.stall", o_stall, 0);
      chk("tmo.wbv", o_wb_valid, 1);
      chk("tmo.wbwe", o_wb_we, 0);
      tick();
      chk("tmo.fault_pulse", o_mem_fault, 0);
      chk("tmo.wbv_pulse", o_wb_valid, 0);
`endif

      // randomized instruction stream against the reference memory
      for (int n = 0; n < 40; n++) begin
         r_op  = 2'($urandom_range(0, 3));
         r_res = (r_op == 2'b01 || r_op == 2'b10) ? DW'($urandom_range(0, 7) * 2)
                                                  : DW'($urandom);
         r_lat = $urandom_range(0, TO - 1);
         r_fk  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, r_lat) : -1;
         run_instr(r_op, r_res, DW'($urandom), RW'($urandom), 1'($urandom),
                   r_lat, r_fk, "rand");
         if ($urandom_range(0, 2) == 0) begin
            r_v = 1'($urandom);
            idle_cycle(r_v, r_v ? 1'b1 : 1'($urandom), 1'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
